fp_stim_gen: RTL and testbench
==============================

FP_STIM_GEN -- requirements
Module: fp_stim_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning total operand width.
REQ-002 SHALL have parameter EXP_BITS, default 8, meaning exponent field width.
REQ-003 SHALL have parameter MANT_BITS, default 23, meaning mantissa field width; WIDTH == 1+EXP_BITS+MANT_BITS is checked at elaboration.
REQ-004 SHALL have parameter SEED, default 32'hACE1_5EED, meaning non-zero LFSR reset seed.
REQ-005 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1, asynchronous active-low reset), listed first in that order.
REQ-006 SHALL have port start (input, 1): request a run.
REQ-007 SHALL have port mode (input, 4): stimulus mode, sampled on start.
REQ-008 SHALL have port op_mode (input, 2): 0 add, 1 sub, 2 random, 3 alternate; sampled on start.
REQ-009 SHALL have port count (input, 16): vectors per run, sampled on start.
REQ-010 SHALL have ports spec_a and spec_b (input, WIDTH each): operands for SPECIFIC mode, sampled on start.
REQ-011 SHALL have port out_ready (input, 1): consumer accepts the vector.
REQ-012 SHALL have ports out_valid (output, 1), a (output, WIDTH), b (output, WIDTH) and operation_select (output, 1; 0 add, 1 sub).
REQ-013 SHALL have ports busy (output, 1) and done (output, 1; one-cycle pulse).

Function
REQ-014 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE on the final handshake; DONE->IDLE after one cycle.
REQ-015 SHALL ignore start outside IDLE, and SHALL go IDLE->DONE directly when start is accepted with count==0, producing no vectors.
REQ-016 SHALL assert out_valid the first cycle after start is accepted, with the first vector presented then.
REQ-017 SHALL hold out_valid, a, b and operation_select stable while out_valid && !out_ready.
REQ-018 SHALL on each out_valid && out_ready either present the next vector in the following cycle (no bubble) or, if it was the count-th vector, deassert out_valid.
REQ-019 SHALL implement modes 0 ZERO (a=b=0), 1 RANDOM (a, b from independent LFSRs) and 2 A_GT_B (random pair, unsigned a>b; if equal, b=a-1; if both are 0, a=1).
REQ-020 SHALL implement modes 3 MAX_POS (sign 0, exp all-ones-minus-one, mant all ones), 4 MAX_NEG (as MAX_POS with sign 1) and 5 MIN_NORM_POS (exp 1, mant 0), each applied to both operands.
REQ-021 SHALL implement modes 6 MIN_DENORM_POS (exp 0, mant 1), 7 CUSTOM (sign 0, exp {1, zeros, 2 random LSBs}, mant {3 random MSBs, zeros}) and 8 SPECIFIC (spec_a/spec_b every vector).
REQ-022 SHALL treat modes 9-15 as ZERO.
REQ-023 SHALL set operation_select per op_mode: constant 0, constant 1, LFSR bit, or toggling per vector starting at 0.
REQ-024 SHALL use two 32-bit Galois LFSRs, polynomial x^32+x^22+x^2+x+1, seeded SEED and ~SEED and advanced only on handshakes; 32-bit LFSR values are replicated or truncated to WIDTH.
REQ-025 SHALL use a 16-bit vector counter with no wrap; it cannot exceed count.
REQ-026 SHALL assert busy in RUN and DONE, and pulse done high for exactly the DONE cycle.

Reset
REQ-027 SHALL on rst_n low, at any time including mid-run, immediately set state IDLE, out_valid 0, a 0, b 0, operation_select 0, busy 0, done 0, counter 0 and LFSRs to their seeds.
REQ-028 SHALL not emit a done pulse for an aborted run.

Structure
REQ-029 SHALL place the mode enum, op_mode enum, LFSR polynomial constant and FP field-builder functions in shared package fp_stim_pkg.
REQ-030 SHALL instantiate one sub-module, fp_lfsr32 (enable, seed parameter, 32-bit state), twice.

Verification
REQ-031 Mode 3, op_mode 0, count 2, out_ready=1 -> a=b=32'h7F7F_FFFF, operation_select 0 for 2 cycles, then done pulse.
REQ-032 Mode 8, spec_a=spec_b=32'h3F80_0000, count 3, out_ready low 4 cycles then high -> vector stable throughout the stall, 3 transfers.
REQ-033 Mode 2, count 1000, random out_ready -> every transfer satisfies unsigned a>b; exactly 1000 transfers.
REQ-034 Mode 7, count 200 -> each a, b matches 32'h40[0..3 in exp LSBs] pattern: bit31=0, exp in 128..131, mant[19:0]=0.
REQ-035 Mode 1, count 10, rst_n low after 4 transfers -> outputs 0 next sample, no done pulse; rerun reproduces the identical first 4 vectors.
REQ-036 count=0 -> no out_valid, done pulse 1 cycle after start; start during RUN -> ignored.

Source files
------------

// File: rtl/fp_stim_pkg.sv
// fp_stim_pkg: shared stimulus modes, op modes, FSM states, LFSR polynomial and FP field builders
package fp_stim_pkg;
  typedef enum logic [3:0] {
    M_ZERO, M_RANDOM, M_A_GT_B, M_MAX_POS, M_MAX_NEG,
    M_MIN_NORM_POS, M_MIN_DENORM_POS, M_CUSTOM, M_SPECIFIC
  } stim_mode_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_RANDOM, OP_ALT} op_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [63:0] fp_pack(input logic s, input logic [31:0] e, input logic [31:0] m,
                                          input int eb, input int mb);
    logic [63:0] em, mm;
    em = (64'd1 << eb) - 64'd1;
    mm = (64'd1 << mb) - 64'd1;
    return ({63'd0, s} << (eb + mb)) | (({32'd0, e} & em) << mb) | ({32'd0, m} & mm);
  endfunction
  function automatic logic [63:0] fp_max(input logic s, input int eb, input int mb);
    return fp_pack(s, 32'((1 << eb) - 2), '1, eb, mb);
  endfunction
  function automatic logic [63:0] fp_custom(input logic [4:0] r, input int eb, input int mb);
    return fp_pack(1'b0, (32'd1 << (eb - 1)) | {30'd0, r[1:0]}, {29'd0, r[4:2]} << (mb - 3), eb, mb);
  endfunction
endpackage

// File: rtl/fp_lfsr32.sv
// fp_lfsr32: 32-bit Galois LFSR (clk, rst_n async low, en advances one step, state = current value)
module fp_lfsr32 import fp_stim_pkg::*; #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] state
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEED;
    else if (en) state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'd0);
endmodule

// File: rtl/fp_stim_gen.sv
// fp_stim_gen: FP operand pair generator (start/mode/op_mode/count/spec_a/spec_b in, valid/ready stream of a, b, operation_select out, busy/done status)
module fp_stim_gen import fp_stim_pkg::*; #(
  parameter int          WIDTH     = 32,
  parameter int          EXP_BITS  = 8,
  parameter int          MANT_BITS = 23,
  parameter logic [31:0] SEED      = 32'hACE1_5EED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       mode,
  input  logic [1:0]       op_mode,
  input  logic [15:0]      count,
  input  logic [WIDTH-1:0] spec_a,
  input  logic [WIDTH-1:0] spec_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             operation_select,
  output logic             busy,
  output logic             done
);
  if (WIDTH != 1 + EXP_BITS + MANT_BITS) begin : g_width_check
    $error("fp_stim_gen: WIDTH must equal 1+EXP_BITS+MANT_BITS");
  end
  state_e state, state_n;
  logic [3:0] mode_q;
  logic [1:0] op_q;
  logic [15:0] cnt_max, cnt;
  logic [WIDTH-1:0] sa_q, sb_q, ra, rb, hi, lo, va, vb;
  logic [31:0] ra32, rb32;
  logic tog, hs, last;
  function automatic logic [WIDTH-1:0] widen(input logic [31:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[i % 32];
    return r;
  endfunction
  fp_lfsr32 #(.SEED(SEED))  u_lfsr_a (.clk(clk), .rst_n(rst_n), .en(hs), .state(ra32));
  fp_lfsr32 #(.SEED(~SEED)) u_lfsr_b (.clk(clk), .rst_n(rst_n), .en(hs), .state(rb32));
  assign hs = out_valid && out_ready;
  assign last = cnt == cnt_max - 16'd1;
  assign out_valid = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? (count == 16'd0 ? DONE : RUN) :
              (state == RUN && hs && last) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= '0;
      op_q <= '0;
      cnt_max <= '0;
      cnt <= '0;
      sa_q <= '0;
      sb_q <= '0;
      tog <= 1'b0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
      op_q <= op_mode;
      cnt_max <= count;
      cnt <= '0;
      sa_q <= spec_a;
      sb_q <= spec_b;
      tog <= 1'b0;
    end else if (hs) begin
      cnt <= cnt + 16'd1;
      tog <= ~tog;
    end
  assign ra = widen(ra32);
  assign rb = widen(rb32);
  // Order the random pair so a > b; equal values collapse to (x, x-1), or (1, 0) when both are zero.
  assign hi = (ra > rb) ? ra : (rb > ra) ? rb : (ra == '0) ? WIDTH'(1) : ra;
  assign lo = (ra > rb) ? rb : (rb > ra) ? ra : (ra == '0) ? '0 : ra - WIDTH'(1);
  always_comb begin
    va = '0;
    vb = '0;
    case (mode_q)
      M_RANDOM:         begin va = ra; vb = rb; end
      M_A_GT_B:         begin va = hi; vb = lo; end
      M_MAX_POS:        begin va = WIDTH'(fp_max(1'b0, EXP_BITS, MANT_BITS)); vb = va; end
      M_MAX_NEG:        begin va = WIDTH'(fp_max(1'b1, EXP_BITS, MANT_BITS)); vb = va; end
      M_MIN_NORM_POS:   begin va = WIDTH'(fp_pack(1'b0, 32'd1, 32'd0, EXP_BITS, MANT_BITS)); vb = va; end
      M_MIN_DENORM_POS: begin va = WIDTH'(fp_pack(1'b0, 32'd0, 32'd1, EXP_BITS, MANT_BITS)); vb = va; end
      M_CUSTOM:         begin
                          va = WIDTH'(fp_custom(ra32[4:0], EXP_BITS, MANT_BITS));
                          vb = WIDTH'(fp_custom(rb32[4:0], EXP_BITS, MANT_BITS));
                        end
      M_SPECIFIC:       begin va = sa_q; vb = sb_q; end
      default:          ;
    endcase
  end
  // Outputs are derived from the LFSR state, which only moves on a handshake, so they hold during stalls.
  assign a = out_valid ? va : '0;
  assign b = out_valid ? vb : '0;
  assign operation_select = out_valid && (op_q == OP_ADD ? 1'b0 : op_q == OP_SUB ? 1'b1 :
                                          op_q == OP_RANDOM ? ra32[31] : tog);
endmodule

// File: tb/tb_fp_stim_gen.sv
// tb_fp_stim_gen: scoreboard bench for fp_stim_gen
module tb_fp_stim_gen;
  localparam logic [31:0] SEED = 32'hACE1_5EED;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [3:0] mode = '0;
  logic [1:0] op_mode = '0;
  logic [15:0] count = '0;
  logic [31:0] spec_a = '0, spec_b = '0;
  logic out_valid, operation_select, busy, done;
  logic [31:0] a, b;
  typedef struct { logic [31:0] a, b; logic op; } vec_t;
  typedef struct {
    logic [3:0] mode; logic [1:0] op; logic [15:0] cnt;
    logic [31:0] sa, sb; logic fixed; logic [31:0] ea, eb;
  } rec_t;
  vec_t exp_q[$], log_q[$], saved[$];
  int n_cmp = 0, n_err = 0, n_xfer = 0, n_done = 0;
  logic [31:0] mra, mrb;
  logic [3:0] cur_mode = '0;

  fp_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .op_mode(op_mode),
    .count(count), .spec_a(spec_a), .spec_b(spec_b), .out_ready(out_ready),
    .out_valid(out_valid), .a(a), .b(b), .operation_select(operation_select),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic vec_t mk(input rec_t r, input logic [31:0] x, input logic [31:0] y, input logic tg);
    vec_t v;
    v.a = '0;
    v.b = '0;
    case (r.mode)
      4'd1: begin v.a = x; v.b = y; end
      4'd2: if (x > y) begin v.a = x; v.b = y; end
            else if (y > x) begin v.a = y; v.b = x; end
            else if (x == 0) begin v.a = 32'd1; v.b = 32'd0; end
            else begin v.a = x; v.b = x - 32'd1; end
      4'd3: begin v.a = 32'h7F7F_FFFF; v.b = 32'h7F7F_FFFF; end
      4'd4: begin v.a = 32'hFF7F_FFFF; v.b = 32'hFF7F_FFFF; end
      4'd5: begin v.a = 32'h0080_0000; v.b = 32'h0080_0000; end
      4'd6: begin v.a = 32'h0000_0001; v.b = 32'h0000_0001; end
      4'd7: begin v.a = {2'b01, 5'b0, x[1:0], x[4:2], 20'b0}; v.b = {2'b01, 5'b0, y[1:0], y[4:2], 20'b0}; end
      4'd8: begin v.a = r.sa; v.b = r.sb; end
      default: ;
    endcase
    v.op = r.op == 2'd0 ? 1'b0 : r.op == 2'd1 ? 1'b1 : r.op == 2'd2 ? x[31] : tg;
    return v;
  endfunction

  always @(negedge clk) begin
    vec_t e, g;
    if (done) n_done++;
    if (out_valid && out_ready) begin
      g = '{a, b, operation_select};
      n_xfer++;
      log_q.push_back(g);
      if (exp_q.size() == 0) chk("unexpected xfer", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("xfer a", a, e.a);
        chk("xfer b", b, e.b);
        chk("xfer op", {31'd0, operation_select}, {31'd0, e.op});
      end
      if (cur_mode == 4'd2) chk("a_gt_b", {31'd0, a > b}, 32'd1);
      if (cur_mode == 4'd7) begin
        chk("custom a", a & 32'hFE0F_FFFF, 32'h4000_0000);
        chk("custom b", b & 32'hFE0F_FFFF, 32'h4000_0000);
      end
    end
  end

  task automatic push(input rec_t r);
    logic tg = 1'b0;
    for (int i = 0; i < int'(r.cnt); i++) begin
      exp_q.push_back(mk(r, mra, mrb, tg));
      mra = nxt(mra);
      mrb = nxt(mrb);
      tg = ~tg;
    end
  endtask

  task automatic drive_start(input rec_t r);
    push(r);
    cur_mode = r.mode;
    log_q.delete();
    mode = r.mode; op_mode = r.op; count = r.cnt; spec_a = r.sa; spec_b = r.sb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input rec_t r, input bit rnd, input int stall, output int cyc);
    int x0, d0;
    x0 = n_xfer;
    d0 = n_done;
    drive_start(r);
    cyc = 0;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      chk("stall valid", {31'd0, out_valid}, 32'd1);
      chk("stall a", a, r.sa);
      chk("stall b", b, r.sb);
      chk("stall op", {31'd0, operation_select}, {31'd0, r.op[0]});
      if (i == 1) begin start = 1'b1; mode = 4'd0; count = 16'd0; end
      if (i == 2) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    while (!done && cyc < 5000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("done timeout", 32'd0, 32'd1);
    chk("busy in done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("xfer count", n_xfer - x0, {16'd0, r.cnt});
    chk("done pulses", n_done - d0, 32'd1);
    chk("done width", {31'd0, done}, 32'd0);
    chk("idle busy", {31'd0, busy}, 32'd0);
    chk("queue empty", exp_q.size(), 32'd0);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    #3;
    exp_q.delete();
    mra = SEED;
    mrb = ~SEED;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rec_t tbl[9];
    rec_t r;
    int cyc, x0, d0;
    tbl[0] = '{4'd3, 2'd0, 16'd2, 32'd0, 32'd0, 1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF};
    tbl[1] = '{4'd4, 2'd1, 16'd3, 32'd0, 32'd0, 1'b1, 32'hFF7F_FFFF, 32'hFF7F_FFFF};
    tbl[2] = '{4'd5, 2'd3, 16'd4, 32'd0, 32'd0, 1'b1, 32'h0080_0000, 32'h0080_0000};
    tbl[3] = '{4'd6, 2'd2, 16'd3, 32'd0, 32'd0, 1'b1, 32'h0000_0001, 32'h0000_0001};
    tbl[4] = '{4'd0, 2'd3, 16'd2, 32'd0, 32'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[5] = '{4'd12, 2'd0, 16'd2, 32'd5, 32'd6, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{4'd8, 2'd1, 16'd2, 32'h4049_0FDB, 32'hC000_0000, 1'b1, 32'h4049_0FDB, 32'hC000_0000};
    tbl[7] = '{4'd1, 2'd2, 16'd5, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[8] = '{4'd0, 2'd0, 16'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    mra = SEED;
    mrb = ~SEED;
    #12;
    chk("reset valid", {31'd0, out_valid}, 32'd0);
    chk("reset a", a, 32'd0);
    chk("reset b", b, 32'd0);
    chk("reset op", {31'd0, operation_select}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run(tbl[i], 1'b0, 0, cyc);
      chk("latency", cyc, {16'd0, tbl[i].cnt});
      if (tbl[i].fixed && log_q.size() > 0) begin
        chk("first a", log_q[0].a, tbl[i].ea);
        chk("first b", log_q[0].b, tbl[i].eb);
      end
    end
    r = '{4'd8, 2'd1, 16'd3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'd0, 32'd0};
    run(r, 1'b0, 4, cyc);
    chk("stall latency", cyc, 32'd7);
    r = '{4'd2, 2'd2, 16'd1000, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    run(r, 1'b1, 0, cyc);
    r = '{4'd7, 2'd3, 16'd200, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    run(r, 1'b0, 0, cyc);
    reset_all();
    r = '{4'd1, 2'd2, 16'd10, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    x0 = n_xfer;
    d0 = n_done;
    drive_start(r);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort valid", {31'd0, out_valid}, 32'd0);
    chk("abort a", a, 32'd0);
    chk("abort b", b, 32'd0);
    chk("abort op", {31'd0, operation_select}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort xfers", n_xfer - x0, 32'd4);
    saved = log_q;
    exp_q.delete();
    mra = SEED;
    mrb = ~SEED;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort no done", n_done - d0, 32'd0);
    r.cnt = 16'd4;
    run(r, 1'b0, 0, cyc);
    if (log_q.size() >= 4 && saved.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("rerun a", log_q[i].a, saved[i].a);
        chk("rerun b", log_q[i].b, saved[i].b);
      end
    else chk("rerun length", log_q.size(), 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
